sdram_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 16 +
 rtl/sdram_refresh_timer.sv | 42 ++++
 rtl/sdram_arbiter.sv | 125 ++++++++++++
 tb/tb_sdram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM arbiter slice.
// State encoding, refresh interval default and port indices.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    REFRESH = 2'd2
  } state_t;

  localparam int REFRESH_CYCLES_DEF = 780;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh down-counter with pending and sticky-miss flags.
// Ports: i_clk, i_rst (sync, active-high), i_clr (refresh served),
//        o_pending (refresh owed), o_miss (deadline missed, sticky).
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_pending,
  output logic o_miss
);

  localparam int CW =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_expire;

  assign w_expire = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= RELOAD;
      o_pending <= 1'b0;
      o_miss    <= 1'b0;
    end else begin
      r_cnt <= w_expire ? RELOAD : r_cnt - 1'b1;
      // a new expiry outranks a same-cycle service
      if (w_expire)
        o_pending <= 1'b1;
      else if (i_clr)
        o_pending <= 1'b0;
      if (w_expire && o_pending)
        o_miss <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM access arbiter with periodic auto-refresh scheduling.
// Ports: clock/reset (sync, active-high); req/we/addr/dataW/ack per
//   requester; dataR shared read data; mem* downstream handshake;
//   busy (not IDLE); refreshMiss (sticky).
// Build option: SDRAM_ARB_FIXED_PRIO_EN gives port 0 fixed priority
//   instead of round-robin.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW             = 24,
  parameter int DW             = 16,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] dataW0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] dataW1,
  output logic          ack1,
  output logic [DW-1:0] dataR,
  output logic          memReq,
  output logic          memWe,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memDataW,
  output logic          memRefresh,
  input  logic          memAck,
  input  logic [DW-1:0] memDataR,
  output logic          busy,
  output logic          refreshMiss
);

  state_t r_state;
  logic   r_gnt;
  logic   w_pick;
  logic   w_ref_pend;
  logic   w_ref_clr;

  assign w_ref_clr = (r_state == REFRESH) && memAck;

  sdram_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_timer (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_clr    (w_ref_clr),
    .o_pending(w_ref_pend),
    .o_miss   (refreshMiss)
  );

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign w_pick = req0 ? PORT0 : PORT1;
`else
  logic r_last;
  // on contention favour the port that was not served last
  assign w_pick = (req0 && req1) ? ~r_last
                : (req0 ? PORT0 : PORT1);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= PORT0;
      memReq     <= 1'b0;
      memRefresh <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memDataW   <= '0;
      dataR      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      r_last     <= PORT1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_ref_pend) begin
            r_state    <= REFRESH;
            memRefresh <= 1'b1;
            busy       <= 1'b1;
          end else if (req0 || req1) begin
            r_state  <= ACCESS;
            r_gnt    <= w_pick;
            memReq   <= 1'b1;
            busy     <= 1'b1;
            memWe    <= w_pick ? we1 : we0;
            memAddr  <= w_pick ? addr1 : addr0;
            memDataW <= w_pick ? dataW1 : dataW0;
          end
        end
        ACCESS: begin
          if (memAck) begin
            r_state <= IDLE;
            memReq  <= 1'b0;
            busy    <= 1'b0;
            dataR   <= memDataR;
            ack0    <= (r_gnt == PORT0);
            ack1    <= (r_gnt == PORT1);
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            r_last  <= r_gnt;
`endif
          end
        end
        REFRESH: begin
          if (memAck) begin
            r_state    <= IDLE;
            memRefresh <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: vector table, corner
// sequences and randomized traffic against a cycle reference model.
module tb_sdram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int RC = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] dataW0, dataW1;
  logic          ack0, ack1;
  logic [DW-1:0] dataR;
  logic          memReq, memWe, memRefresh, memAck;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memDataW, memDataR;
  logic          busy, refreshMiss;

  sdram_arbiter #(
    .AW(AW), .DW(DW), .REFRESH_CYCLES(RC)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0),
    .dataW0(dataW0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1),
    .dataW1(dataW1), .ack1(ack1),
    .dataR(dataR),
    .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memDataW(memDataW),
    .memRefresh(memRefresh), .memAck(memAck),
    .memDataR(memDataR),
    .busy(busy), .refreshMiss(refreshMiss)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: who holds the memory (-1 none, 0/1 port, 2 refresh)
  int            m_owner;
  int            m_t;
  bit            m_pend, m_miss, m_last, m_due, m_srv;
  logic          m_ack0, m_ack1, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dw, m_dr;
  bit            chk_en = 0;

  function automatic int pick(input logic r0, input logic r1,
                              input bit last);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    return r0 ? 0 : 1;
`else
    if (r0 && r1) return last ? 0 : 1;
    return r0 ? 0 : 1;
`endif
  endfunction

  task automatic model_edge();
    int p;
    if (reset) begin
      m_owner = -1; m_t = 0; m_pend = 0; m_miss = 0; m_last = 1;
      m_ack0 = 0; m_ack1 = 0; m_we = 0;
      m_addr = '0; m_dw = '0; m_dr = '0;
      return;
    end
    m_t++;
    m_due = (m_t % RC) == 0;
    m_srv = (m_owner == 2) && memAck;
    m_ack0 = 0;
    m_ack1 = 0;
    if (m_owner == -1) begin
      if (m_pend) m_owner = 2;
      else if (req0 || req1) begin
        p = pick(req0, req1, m_last);
        m_owner = p;
        m_we   = (p == 1) ? we1 : we0;
        m_addr = (p == 1) ? addr1 : addr0;
        m_dw   = (p == 1) ? dataW1 : dataW0;
      end
    end else if (memAck) begin
      if (m_owner != 2) begin
        if (m_owner == 0) m_ack0 = 1;
        else m_ack1 = 1;
        m_dr = memDataR;
        m_last = (m_owner == 1);
      end
      m_owner = -1;
    end
    if (m_due && m_pend) m_miss = 1;
    if (m_due) m_pend = 1;
    else if (m_srv) m_pend = 0;
  endtask

  task automatic cmp(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    logic [63:0] g, e;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (chk_en) begin
      e = {1'b0,
           m_owner == 0 || m_owner == 1, m_owner == 2, m_we,
           m_addr, m_dw, m_ack0, m_ack1, m_dr,
           m_owner != -1, m_miss};
      g = {1'b0, memReq, memRefresh, memWe, memAddr, memDataW,
           ack0, ack1, dataR, busy, refreshMiss};
      cmp("model", g, e);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = '0; dataW0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; dataW1 = '0;
    memAck = 0; memDataR = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic ack; logic [DW-1:0] mdr;
    logic e_req, e_ref, e_we; logic [AW-1:0] e_addr;
    logic e_ack0, e_ack1; logic [DW-1:0] e_dr; logic e_busy;
  } vec_t;

  vec_t tbl[7];
  int   order[$];
  int   exp_ord[4];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 24'h123, 16'hBEEF,
               1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 16'h0,
               1'b1, 1'b0, 1'b1, 24'h123, 1'b0, 1'b0, 16'h0, 1'b1};
    tbl[1] = tbl[0];
    tbl[2] = tbl[0];
    tbl[3] = '{1'b1, 1'b1, 24'h123, 16'hBEEF,
               1'b0, 1'b0, 24'h0, 16'h0, 1'b1, 16'h1111,
               1'b0, 1'b0, 1'b1, 24'h123, 1'b1, 1'b0, 16'h1111, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 24'h0, 16'h0,
               1'b1, 1'b0, 24'h456, 16'h0, 1'b0, 16'h0,
               1'b1, 1'b0, 1'b0, 24'h456, 1'b0, 1'b0, 16'h1111, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 24'h0, 16'h0,
               1'b1, 1'b0, 24'h456, 16'h0, 1'b1, 16'h5A5A,
               1'b0, 1'b0, 1'b0, 24'h456, 1'b0, 1'b1, 16'h5A5A, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 24'h0, 16'h0,
               1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 16'h0,
               1'b0, 1'b0, 1'b0, 24'h456, 1'b0, 1'b0, 16'h5A5A, 1'b0};
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 0, 1};
`endif

    idle_inputs();
    reset = 1;
    step();
    do_reset();
    chk_en = 1;
    cmp("reset_state",
        {memReq, memRefresh, memWe, memAddr, memDataW, dataR,
         ack0, ack1, busy, refreshMiss}, '0);

    // vector table: port 0 write then port 1 read
    for (int i = 0; i < 7; i++) begin
      req0 = tbl[i].r0; we0 = tbl[i].w0;
      addr0 = tbl[i].a0; dataW0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1;
      addr1 = tbl[i].a1; dataW1 = tbl[i].d1;
      memAck = tbl[i].ack; memDataR = tbl[i].mdr;
      step();
      cmp($sformatf("vec%0d", i),
          {memReq, memRefresh, memWe, memAddr, ack0, ack1,
           dataR, busy},
          {tbl[i].e_req, tbl[i].e_ref, tbl[i].e_we, tbl[i].e_addr,
           tbl[i].e_ack0, tbl[i].e_ack1, tbl[i].e_dr,
           tbl[i].e_busy});
    end

    // both ports held: grant order
    idle_inputs();
    do_reset();
    req0 = 1; addr0 = 24'hA0; req1 = 1; addr1 = 24'hB1;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      step();
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
      memAck = (memReq || memRefresh) && !memAck;
    end
    if (order.size() < 4) begin
      n_vec++; n_bad++;
      $display("FAIL rr_timeout: got %0d grants expected 4",
               order.size());
    end else
      for (int k = 0; k < 4; k++)
        cmp($sformatf("rr_grant%0d", k), 64'(order[k]),
            64'(exp_ord[k]));

    // refresh deferred behind a long access, then missed
    idle_inputs();
    do_reset();
    req0 = 1; addr0 = 24'h777;
    for (int c = 0; c < 21; c++) step();
    cmp("ref_wait_access", {memReq, memRefresh}, 64'b10);
    memAck = 1;
    step();
    cmp("ref_after_ack", {ack0, memReq, memRefresh}, 64'b100);
    memAck = 0; req0 = 0;
    step();
    cmp("ref_first_idle", {memReq, memRefresh, busy}, 64'b011);
    for (int c = 0; c < 10; c++) step();
    cmp("ref_miss", {memRefresh, refreshMiss}, 64'b11);
    memAck = 1;
    step();
    memAck = 0;
    step();
    step();
    cmp("ref_miss_sticky", {busy, refreshMiss}, 64'b01);

    // pending refresh and req0 together in IDLE
    idle_inputs();
    do_reset();
    for (int c = 0; c < 16; c++) step();
    req0 = 1; we0 = 1; addr0 = 24'hABC; dataW0 = 16'h1234;
    step();
    cmp("both_refresh_first", {memReq, memRefresh}, 64'b01);
    memAck = 1;
    step();
    memAck = 0;
    step();
    cmp("both_then_req", {memReq, memAddr}, {1'b1, 24'hABC});

    // reset during an access
    idle_inputs();
    do_reset();
    req0 = 1; addr0 = 24'h222;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    cmp("rst_mid_access", {memReq, busy, ack0}, 64'b000);
    step();
    cmp("rst_regrant", {memReq, memAddr}, {1'b1, 24'h222});
    memAck = 1;
    step();
    cmp("rst_ack", {ack0, ack1}, 64'b10);
    memAck = 0; req0 = 0;
    step();

    // randomized protocol-abiding traffic
    idle_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (ack0 || !req0) begin
        req0 = ($urandom % 3) == 0; we0 = $urandom % 2;
        addr0 = AW'($urandom); dataW0 = DW'($urandom);
      end
      if (ack1 || !req1) begin
        req1 = ($urandom % 3) == 0; we1 = $urandom % 2;
        addr1 = AW'($urandom); dataW1 = DW'($urandom);
      end
      if ((memReq || memRefresh) && !memAck)
        memAck = ($urandom % 3) == 0;
      else if (memAck)
        memAck = 0;
      else
        memAck = ($urandom % 12) == 0;
      memDataR = DW'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
